vga_stream_sink: RTL and testbench
==================================

Name: vga_stream_sink

Overview:
- Terminal consumer of the pixel stream (color + start-of-frame bit) at the output side of the line buffer, in the pixel clock domain.
- Generates VGA timing (hsync, vsync, pixel counters) and pulls one stream word per visible pixel.
- Locks the stream to frame origin using the start bit and recovers automatically from underrun or misalignment.

Parameters:
- CD, 12, color depth; stream word is CD+1 bits, bit CD = start-of-frame.
- H_DISPLAY, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- si_data  in  CD+1  stream word: [CD] = start, [CD-1:0] = color.
- si_valid  in  1  stream word present.
- si_ready  out  1  word consumed this cycle when si_valid & si_ready.
- hsync  out  1  horizontal sync, active low, registered.
- vsync  out  1  vertical sync, active low, registered.
- rgb  out  CD  pixel color, registered; 0 when blanked.
- hc  out  11  current horizontal count, combinational from counter.
- vc  out  11  current vertical count, combinational from counter.
- underrun  out  1  one-cycle pulse, registered.
- misalign  out  1  one-cycle pulse, registered.

Behaviour:
- Derived values:
  - H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP (800).
  - V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP (525).
  - video_on = (hc < H_DISPLAY) & (vc < V_DISPLAY).
  - org = (hc == 0) & (vc == 0).
- Counters:
  - hc increments every cycle and wraps from H_TOTAL-1 to 0.
  - vc increments when hc wraps and itself wraps from V_TOTAL-1 to 0.
  - Counters free-run in every state and never stall on the stream.
- Sync:
  - hsync_next = 0 iff H_DISPLAY+H_FP <= hc <= H_DISPLAY+H_FP+H_SYNC-1 (656..751).
  - vsync_next = 0 iff V_DISPLAY+V_FP <= vc <= V_DISPLAY+V_FP+V_SYNC-1 (490..491).
- Output timing: hsync, vsync, rgb, underrun and misalign are registered with 1-cycle latency from the (hc, vc) they describe; all are mutually aligned.
- State SEARCH (reset state):
  - si_ready = ~(si_valid & si_data[CD]). Non-start words are drained at one per cycle; a start word is held at the head.
  - If org & si_valid & si_data[CD]: assert si_ready, consume the word, rgb_next = color, move to LOCKED.
  - Otherwise rgb_next = 0.
- State LOCKED:
  - si_ready = video_on & si_valid & (si_data[CD] == org), combinational.
  - When video_on and the word is consumed: rgb_next = color.
  - video_on & ~si_valid: underrun_next = 1, rgb_next = 0, move to SEARCH.
  - video_on & si_valid & (si_data[CD] != org): misalign_next = 1, word not consumed, rgb_next = 0, move to SEARCH.
  - A start word waiting at a non-origin position is therefore picked up at the next org.
  - ~video_on: si_ready = 0, rgb_next = 0.
- Sticky behaviour: after an error, rgb stays 0 until relock at the next frame origin; no further error pulses are issued while in SEARCH.
- Reset values: state = SEARCH, hc = 0, vc = 0, hsync = 1, vsync = 1, rgb = 0, underrun = 0, misalign = 0. si_ready follows SEARCH rules as soon as reset deasserts.
- Reset mid-operation: all registers take reset values immediately (asynchronous); words already accepted are not replayed.
- Timing parameters are static; no runtime reconfiguration.

Optional Feature:
- Macro: VGA_STREAM_SINK_ERR_CNT_EN.
- Defined: adds output err_cnt[15:0], a saturating count of underrun and misalign pulses.
  - Increments by 1 per pulse and holds at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then continuous valid frame stream with start on word 0 -> lock at (0,0); rgb at cycle 1 equals word 0 color; exactly 307200 words consumed per 420000-cycle frame; hsync low 96 of every 800 cycles; vsync low 1600 cycles per frame.
- Stream begins with 100 non-start words followed by a start word -> 100 words drained in SEARCH, start word held until org, rgb = 0 until relock, then normal frame.
- si_valid dropped at (hc=10, vc=5) in LOCKED -> underrun = 1 for one cycle at +1; rgb = 0 for the rest of the frame; relock at next org when a start word is supplied.
- Start word presented at (320,100) in LOCKED -> misalign pulse, si_ready = 0 for that word; the same word is consumed at the next (0,0).
- Assert reset at hc = 400 mid-line -> hsync = 1, vsync = 1, rgb = 0, hc = vc = 0 without waiting for a clock edge; clean relock after release.
- With VGA_STREAM_SINK_ERR_CNT_EN: force 3 underruns in 3 frames -> err_cnt = 3; preload near saturation -> holds at 16'hFFFF.

Source files
------------

// File: rtl/vga_stream_sink_if.sv
// Pixel stream link between the line buffer output and the VGA sink.
// Word layout: [CD] = start-of-frame, [CD-1:0] = color.
interface vga_stream_sink_if #(
  parameter int CD = 12
);
  logic [CD:0] si_data;
  logic        si_valid;
  logic        si_ready;

  modport master (output si_data, output si_valid, input si_ready);
  modport slave  (input si_data, input si_valid, output si_ready);
endinterface

// File: rtl/vga_stream_sink.sv
// VGA stream sink: free-running VGA timing that pulls one stream word per
// visible pixel, locks to frame origin via the start bit and drops back to
// SEARCH on underrun or misalignment until the next frame origin.
// Optional macro VGA_STREAM_SINK_ERR_CNT_EN adds err_cnt[15:0], a saturating
// count of underrun/misalign pulses.
module vga_stream_sink #(
  parameter int CD        = 12,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic              clk,
  input  logic              reset,
  vga_stream_sink_if.slave  si,
  output logic              hsync,
  output logic              vsync,
  output logic [CD-1:0]     rgb,
  output logic [10:0]       hc,
  output logic [10:0]       vc,
  output logic              underrun,
  output logic              misalign
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS      = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START   = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START   = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_DISPLAY + V_FP + V_SYNC - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_next;
  logic [10:0]   hc_q, vc_q;
  logic          h_wrap, v_wrap;
  logic          video_on, org;
  logic          start;
  logic [CD-1:0] color;
  logic          ready;
  logic          hsync_next, vsync_next;
  logic          underrun_next, misalign_next;
  logic [CD-1:0] rgb_next;

  assign hc       = hc_q;
  assign vc       = vc_q;
  assign h_wrap   = (hc_q == H_LAST);
  assign v_wrap   = (vc_q == V_LAST);
  assign video_on = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign org      = (hc_q == '0) && (vc_q == '0);
  assign start    = si.si_data[CD];
  assign color    = si.si_data[CD-1:0];
  assign si.si_ready = ready;

  assign hsync_next = ~((hc_q >= HS_START) && (hc_q <= HS_END));
  assign vsync_next = ~((vc_q >= VS_START) && (vc_q <= VS_END));

  // Free-running pixel/line counters, independent of the stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (h_wrap) begin
      hc_q <= '0;
      vc_q <= v_wrap ? '0 : vc_q + 11'd1;
    end else begin
      hc_q <= hc_q + 11'd1;
    end
  end

  // Lock state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  // Lock at an origin start word; lose lock on any visible-pixel stream fault
  always_comb begin
    state_next = state;
    unique case (state)
      SEARCH: if (org && si.si_valid && start) state_next = LOCKED;
      LOCKED: if (video_on && (!si.si_valid || (start != org))) state_next = SEARCH;
    endcase
  end

  // Handshake and next-cycle pixel/error values for the current position
  always_comb begin
    ready         = 1'b0;
    rgb_next      = '0;
    underrun_next = 1'b0;
    misalign_next = 1'b0;
    unique case (state)
      SEARCH: begin
        // drain non-start words, hold a start word until it meets origin
        ready = ~(si.si_valid & start) | org;
        if (org && si.si_valid && start) rgb_next = color;
      end
      LOCKED: begin
        if (video_on) begin
          ready         = si.si_valid & (start == org);
          underrun_next = ~si.si_valid;
          misalign_next = si.si_valid & (start != org);
          if (ready) rgb_next = color;
        end
      end
    endcase
  end

  // Registered, mutually aligned video and error outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      rgb      <= '0;
      underrun <= 1'b0;
      misalign <= 1'b0;
    end else begin
      hsync    <= hsync_next;
      vsync    <= vsync_next;
      rgb      <= rgb_next;
      underrun <= underrun_next;
      misalign <= misalign_next;
    end
  end

`ifdef VGA_STREAM_SINK_ERR_CNT_EN
  // Saturating error counter, updated on the same edge the pulse appears
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if ((underrun_next || misalign_next) && (err_cnt != '1))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_stream_sink.sv
// Randomized self-checking bench for vga_stream_sink with a reduced raster
// (25 x 13) so that many frames fit in a short run. A behavioural model
// derives raster position from elapsed cycles and applies the lock/stream
// rules directly; hand-computed frame totals pin the model.
module tb_vga_stream_sink;

  localparam int CD = 12;
  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_stream_sink_if #(.CD(CD)) s_if ();

  logic          hsync, vsync, underrun, misalign;
  logic [CD-1:0] rgb;
  logic [10:0]   hc, vc;
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  vga_stream_sink #(
    .CD(CD), .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .si(s_if),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .hc(hc), .vc(vc),
    .underrun(underrun), .misalign(misalign)
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int            m_t;
  bit            m_locked;
  logic          e_hs, e_vs, e_ur, e_ma;
  logic [CD-1:0] e_rgb;
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
  logic [15:0]   e_err;
`endif

  always @(negedge clk) begin
    int h, v;
    bit vis, org, st, rdy, n_ur, n_ma;
    logic [CD-1:0] col, n_rgb;
    if (reset) begin
      m_t = 0; m_locked = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0; e_ur = 1'b0; e_ma = 1'b0;
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
      e_err = '0;
`endif
    end else begin
      h = m_t % HT;
      v = (m_t / HT) % VT;
      check("hc", 32'(hc), 32'(h));
      check("vc", 32'(vc), 32'(v));
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("rgb", 32'(rgb), 32'(e_rgb));
      check("underrun", 32'(underrun), 32'(e_ur));
      check("misalign", 32'(misalign), 32'(e_ma));
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(e_err));
`endif
      vis = (h < HD) && (v < VD);
      org = (h == 0) && (v == 0);
      st  = s_if.si_data[CD];
      col = s_if.si_data[CD-1:0];
      rdy = 0; n_rgb = '0; n_ur = 0; n_ma = 0;
      if (!m_locked) begin
        rdy = !(s_if.si_valid && st) || org;
        if (org && s_if.si_valid && st) begin n_rgb = col; m_locked = 1; end
      end else if (vis) begin
        if (!s_if.si_valid)  begin n_ur = 1; m_locked = 0; end
        else if (st != org)  begin n_ma = 1; m_locked = 0; end
        else                 begin rdy = 1; n_rgb = col; end
      end
      check("si_ready", 32'(s_if.si_ready), 32'(rdy));
      e_hs  = !((h >= HD + HF) && (h < HD + HF + HS));
      e_vs  = !((v >= VD + VF) && (v < VD + VF + VS));
      e_rgb = n_rgb;
      e_ur  = n_ur;
      e_ma  = n_ma;
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
      if ((n_ur || n_ma) && e_err != 16'hFFFF) e_err = e_err + 16'd1;
`endif
      m_t++;
    end
  end

  // ---------------- stream source ----------------
  logic [CD:0] src_q[$];
  bit fire;
  int drop_h = -1, drop_v = -1, inj_h = -1, inj_v = -1, gap_pct = 0;
  int cnt_fire, cnt_hs, cnt_vs, cnt_rgbnz;

  task automatic push_frame(input logic [CD-1:0] c);
    src_q.push_back({1'b1, c});
    for (int i = 1; i < HD * VD; i++) src_q.push_back({1'b0, 12'($urandom_range(1, 4095))});
  endtask

  task automatic drive();
    if (int'(hc) == inj_h && int'(vc) == inj_v) begin
      src_q.delete();
      push_frame(12'($urandom_range(1, 4095)));
      inj_h = -1;
    end
    if (src_q.size() < 256) push_frame(12'($urandom_range(1, 4095)));
    s_if.si_valid = 1'b1;
    s_if.si_data  = src_q[0];
    if ((int'(hc) == drop_h && int'(vc) == drop_v) ||
        (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)) begin
      s_if.si_valid = 1'b0;
      s_if.si_data  = 13'($urandom);
    end
  endtask

  task automatic sample();
    fire = s_if.si_valid && s_if.si_ready;
    cnt_fire  += int'(fire);
    cnt_hs    += int'(!hsync);
    cnt_vs    += int'(!vsync);
    cnt_rgbnz += int'(rgb != '0);
  endtask

  task automatic zero_counts();
    cnt_fire = 0; cnt_hs = 0; cnt_vs = 0; cnt_rgbnz = 0;
  endtask

  // one pixel cycle: pop on handshake, drive new inputs, sample at negedge
  task automatic step();
    @(posedge clk); #1;
    if (fire) void'(src_q.pop_front());
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    bit found = 0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      step();
      if (int'(hc) == h && int'(vc) == v) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    bit found;
    s_if.si_valid = 1'b0;
    s_if.si_data  = '0;
    fire = 0;

    // A: start word at head from reset, lock at origin, frame totals
    reset = 1'b1;
    repeat (3) @(negedge clk);
    src_q.delete();
    push_frame(12'hABC);
    drive();
    zero_counts();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); sample();
    check("sof_ready_at_org", 32'(s_if.si_ready), 32'd1);
    step();
    check("first_rgb", 32'(rgb), 32'hABC);
    repeat (FR - 2) step();
    check("words_per_frame", 32'(cnt_fire), 32'(HD * VD));
    check("hsync_low_per_frame", 32'(cnt_hs), 32'(HS * VT));
    check("vsync_low_per_frame", 32'(cnt_vs), 32'(VS * HT));
    repeat (FR) step();

    // B: underrun at (10,5)
    drop_h = 10; drop_v = 5;
    found = 0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      step();
      if (underrun === 1'b1) found = 1;
    end
    drop_h = -1; drop_v = -1;
    check("underrun_seen", 32'(found), 32'd1);
    check("underrun_hc", 32'(hc), 32'd11);
    check("underrun_vc", 32'(vc), 32'd5);
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
    check("err_cnt_after_ur", 32'(err_cnt), 32'd1);
`endif
    repeat (2 * FR) step();

    // C: start word injected at (8,3) while locked
    inj_h = 8; inj_v = 3;
    found = 0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      step();
      if (misalign === 1'b1) found = 1;
    end
    check("misalign_seen", 32'(found), 32'd1);
    check("misalign_hc", 32'(hc), 32'd9);
    check("misalign_vc", 32'(vc), 32'd3);
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
    check("err_cnt_after_ma", 32'(err_cnt), 32'd2);
`endif
    wait_pos(0, 0, "reach_org_after_ma");
    check("held_sof_taken_at_org", 32'(s_if.si_ready), 32'd1);
    repeat (2 * FR) step();

    // D: asynchronous reset inside hsync+vsync, then 100 junk words before start
    wait_pos(HD + HF + 1, VD + VF, "reach_sync_region");
    check("hsync_low_before_reset", 32'(hsync), 32'd0);
    check("vsync_low_before_reset", 32'(vsync), 32'd0);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hc", 32'(hc), 32'd0);
    check("rst_vc", 32'(vc), 32'd0);
`ifdef VGA_STREAM_SINK_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    src_q.delete();
    for (int i = 0; i < 100; i++) src_q.push_back({1'b0, 12'($urandom_range(1, 4095))});
    drive();
    zero_counts();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); sample();
    check("junk_drained_at_org", 32'(s_if.si_ready), 32'd1);
    repeat (FR - 1) step();
    check("junk_words_drained", 32'(cnt_fire), 32'd100);
    check("rgb_dark_while_search", 32'(cnt_rgbnz), 32'd0);
    zero_counts();
    repeat (FR) step();
    check("relock_frame_words", 32'(cnt_fire), 32'(HD * VD));

    // E: random stream gaps, then clean recovery
    gap_pct = 3;
    repeat (6 * FR) step();
    gap_pct = 0;
    repeat (2 * FR) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
